// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the AXI master bridge.
// Contents:
//   state_e      - bridge FSM states
//   RESP_*       - AXI response encodings
//   BURST_INCR, SIZE_4B, CACHE_NONE - constant AXI address-channel fields
//   crosses_4k() - checks whether a 32-bit INCR burst runs past a 4 KB page
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_AR   = 3'd2,
    ST_R    = 3'd3,
    ST_AW   = 3'd4,
    ST_W    = 3'd5,
    ST_B    = 3'd6,
    ST_ERR  = 3'd7
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [3:0] CACHE_NONE = 4'b0000;

  // Only the page offset matters. The sum is formed 14 bits wide so the
  // worst case (0xFFF + 256 beats * 4 bytes) cannot wrap. Ending exactly
  // on the page boundary (4096) is legal.
  function automatic logic crosses_4k(input logic [11:0] addr, input logic [7:0] len);
    logic [13:0] end_off;
    end_off = {2'b00, addr} + (({6'b000000, len} + 14'd1) << 2);
    return (end_off > 14'd4096);
  endfunction

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Blocking, single-outstanding bridge from a simple request/response memory
// port to an AXI4 master. Each request becomes one INCR burst of 32-bit beats.
// Misaligned requests and requests that would cross a 4 KB page are answered
// locally with SLVERR and never reach AXI.
// Ports:
//   ACLK, ARESETn                  - clock, async active-low reset
//   req_*                          - request (write, addr, len, lock) handshake
//   wd_*                           - write-data stream, passed through to W
//   rsp_*                          - response stream (data, last, resp, write)
//   AW*/W*/B*                      - AXI write channels
//   AR*/R*                         - AXI read channels
module axi_lite_master_bridge
  import axi_bridge_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = {ID_W{1'b0}},
  parameter logic [2:0]      PROT   = 3'b000
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  // request port
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [31:0]     req_addr,
  input  logic [7:0]      req_len,
  input  logic            req_lock,
  // write-data stream
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [31:0]     wd_data,
  input  logic [3:0]      wd_strb,
  // response port
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            rsp_last,
  output logic [1:0]      rsp_resp,
  output logic            rsp_write,
  // AXI write address
  output logic [ID_W-1:0] AWID,
  output logic [31:0]     AWADDR,
  output logic [7:0]      AWLEN,
  output logic [2:0]      AWSIZE,
  output logic [1:0]      AWBURST,
  output logic            AWLOCK,
  output logic [3:0]      AWCACHE,
  output logic [2:0]      AWPROT,
  output logic            AWVALID,
  input  logic            AWREADY,
  // AXI write data
  output logic [31:0]     WDATA,
  output logic [3:0]      WSTRB,
  output logic            WLAST,
  output logic            WVALID,
  input  logic            WREADY,
  // AXI write response
  input  logic [ID_W-1:0] BID,
  input  logic [1:0]      BRESP,
  input  logic            BVALID,
  output logic            BREADY,
  // AXI read address
  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [7:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARLOCK,
  output logic [3:0]      ARCACHE,
  output logic [2:0]      ARPROT,
  output logic            ARVALID,
  input  logic            ARREADY,
  // AXI read data
  input  logic [ID_W-1:0] RID,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic        write_q, write_d;
  logic        lock_q, lock_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        awvalid_q, awvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        req_ready_q, req_ready_d;
  logic        beat_last_s;

  // IDs are not checked; this keeps the inputs visibly consumed.
  logic unused_id_s;
  assign unused_id_s = ^{BID, RID};

  assign beat_last_s = (cnt_q == len_q);

  // Address channels are driven straight from the latched request, so every
  // field stays stable while VALID waits for READY.
  assign AWID    = AXI_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = SIZE_4B;
  assign AWBURST = BURST_INCR;
  assign AWLOCK  = lock_q;
  assign AWCACHE = CACHE_NONE;
  assign AWPROT  = PROT;
  assign AWVALID = awvalid_q;

  assign ARID    = AXI_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = SIZE_4B;
  assign ARBURST = BURST_INCR;
  assign ARLOCK  = lock_q;
  assign ARCACHE = CACHE_NONE;
  assign ARPROT  = PROT;
  assign ARVALID = arvalid_q;

  assign WDATA     = wd_data;
  assign WSTRB     = wd_strb;
  assign req_ready = req_ready_q;

  // State and request registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'h0000_0000;
      len_q       <= 8'h00;
      write_q     <= 1'b0;
      lock_q      <= 1'b0;
      cnt_q       <= 8'h00;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      write_q     <= write_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Next-state logic: request latch, legality check, burst sequencing.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    write_d   = write_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    arvalid_d = arvalid_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          len_d   = req_len;
          write_d = req_write;
          lock_d  = req_lock;
          state_d = ST_CHK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHK: begin
        if ((addr_q[1:0] != 2'b00) || crosses_4k(addr_q[11:0], len_q)) begin
          state_d = ST_ERR;
        end else if (write_q) begin
          awvalid_d = 1'b1;
          state_d   = ST_AW;
        end else begin
          arvalid_d = 1'b1;
          state_d   = ST_AR;
        end
      end
      ST_AR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          cnt_d     = 8'h00;
          state_d   = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_AW: begin
        if (AWREADY) begin
          awvalid_d = 1'b0;
          cnt_d     = 8'h00;
          state_d   = ST_W;
        end else begin
          state_d = ST_AW;
        end
      end
      ST_W: begin
        if (wd_valid && WREADY) begin
          if (beat_last_s) begin
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_W;
        end
      end
      ST_B: begin
        if (BVALID && rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_B;
        end
      end
      ST_R: begin
        // Finish on whichever comes first, RLAST or our own beat count, so a
        // slave that gets RLAST wrong cannot hang or overrun the bridge.
        if (RVALID && rsp_ready) begin
          if (RLAST || beat_last_s) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_R;
        end
      end
      ST_ERR: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase

    // req_ready is registered; it is high exactly while the FSM sits in IDLE.
    req_ready_d = (state_d == ST_IDLE);
  end

  // Data/response channel steering: zero added latency through W, B and R.
  always_comb begin
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wd_ready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0000_0000;
    rsp_last  = 1'b0;
    rsp_resp  = RESP_OKAY;
    rsp_write = 1'b0;

    case (state_q)
      ST_W: begin
        WVALID   = wd_valid;
        wd_ready = WREADY;
        WLAST    = beat_last_s;
      end
      ST_B: begin
        BREADY    = rsp_ready;
        rsp_valid = BVALID;
        rsp_resp  = BRESP;
        rsp_last  = 1'b1;
        rsp_write = 1'b1;
      end
      ST_R: begin
        RREADY    = rsp_ready;
        rsp_valid = RVALID;
        rsp_data  = RDATA;
        rsp_last  = beat_last_s;
        // Disagreement between RLAST and the expected beat count is flagged.
        rsp_resp  = (RLAST != beat_last_s) ? RESP_SLVERR : RRESP;
      end
      ST_ERR: begin
        rsp_valid = 1'b1;
        rsp_resp  = RESP_SLVERR;
        rsp_last  = 1'b1;
        rsp_write = write_q;
      end
      default: begin
        rsp_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge. The bench plays the AXI
// slave; expected responses are queued when a request is issued and popped
// as the bridge presents each response beat.
module tb_axi_lite_master_bridge;

  logic        ACLK;
  logic        ARESETn;
  logic        req_valid, req_ready, req_write, req_lock;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWLOCK, ARLOCK, AWVALID, AWREADY, ARVALID, ARREADY;
  logic [3:0]  AWCACHE, ARCACHE, WSTRB;
  logic        WLAST, WVALID, WREADY, BVALID, BREADY, RLAST, RVALID, RREADY;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
    logic        write;
    logic        chk_w;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  axi_lite_master_bridge dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_lock(req_lock),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Issue one request; returns at the negedge after the handshake (FSM in CHK).
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [7:0] len, input logic lock);
    @(negedge ACLK);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len; req_lock = lock;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready === 1'b1) break;
      @(negedge ACLK);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_handshake: req_ready=%b required 1", req_ready);
    end
    @(negedge ACLK);
    req_valid = 1'b0;
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input logic lock,
                          input logic [1:0] resp, input int hold, input logic [31:0] base);
    exp_t e;
    for (int k = 0; k <= int'(len); k++) begin
      e.data = base + k; e.last = (k == int'(len)); e.resp = resp; e.write = 1'b0; e.chk_w = 1'b1;
      sb.push_back(e);
    end
    do_req(1'b0, addr, len, lock);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (ARVALID === 1'b1) break;
    end
    checks++;
    if ({ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARID} !==
        {1'b1, addr, len, 3'b010, 2'b01, lock, 4'b0000, 3'b000, 4'h0}) begin
      errors++;
      $display("FAIL ar_fields: valid=%b addr=%h len=%0d size=%b burst=%b lock=%b required valid=1 addr=%h len=%0d size=010 burst=01 lock=%b",
               ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, addr, len, lock);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge ACLK);
      checks++;
      if ({ARVALID, ARADDR, ARLEN} !== {1'b1, addr, len}) begin
        errors++;
        $display("FAIL ar_stable: valid=%b addr=%h len=%0d required valid=1 addr=%h len=%0d", ARVALID, ARADDR, ARLEN, addr, len);
      end
    end
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      RVALID = 1'b1; RDATA = base + k; RLAST = (k == int'(len)); RRESP = resp;
      #1;
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, RREADY, rsp_data, rsp_last, rsp_resp, rsp_write} !==
          {1'b1, 1'b1, e.data, e.last, e.resp, e.write}) begin
        errors++;
        $display("FAIL read_beat%0d: valid=%b rready=%b data=%h last=%b resp=%b write=%b required 1 1 %h %b %b %b",
                 k, rsp_valid, RREADY, rsp_data, rsp_last, rsp_resp, rsp_write, e.data, e.last, e.resp, e.write);
      end
      @(negedge ACLK);
    end
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL read_done: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input logic lock,
                           input logic [1:0] bresp, input logic [31:0] base);
    exp_t e;
    e.data = 32'h0; e.last = 1'b1; e.resp = bresp; e.write = 1'b1; e.chk_w = 1'b1;
    sb.push_back(e);
    do_req(1'b1, addr, len, lock);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (AWVALID === 1'b1) break;
    end
    checks++;
    if ({AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWID, ARVALID} !==
        {1'b1, addr, len, 3'b010, 2'b01, lock, 4'b0000, 3'b000, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL aw_fields: valid=%b addr=%h len=%0d lock=%b arvalid=%b required valid=1 addr=%h len=%0d lock=%b arvalid=0",
               AWVALID, AWADDR, AWLEN, AWLOCK, ARVALID, addr, len, lock);
    end
    AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0; WREADY = 1'b1;
    for (int k = 0; k <= int'(len); k++) begin
      wd_valid = 1'b1; wd_data = base + k; wd_strb = 4'hF;
      #1;
      checks++;
      if ({WVALID, WDATA, WSTRB, WLAST, wd_ready, rsp_valid} !==
          {1'b1, base + k, 4'hF, (k == int'(len)), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL write_beat%0d: wvalid=%b wdata=%h wstrb=%h wlast=%b wd_ready=%b rsp_valid=%b required 1 %h f %b 1 0",
                 k, WVALID, WDATA, WSTRB, WLAST, wd_ready, rsp_valid, base + k, (k == int'(len)));
      end
      @(negedge ACLK);
    end
    wd_valid = 1'b0; WREADY = 1'b0;
    BVALID = 1'b1; BRESP = bresp;
    #1;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, BREADY, rsp_data, rsp_last, rsp_resp, rsp_write} !==
        {1'b1, 1'b1, e.data, e.last, e.resp, e.write}) begin
      errors++;
      $display("FAIL write_rsp: valid=%b bready=%b data=%h last=%b resp=%b write=%b required 1 1 %h %b %b %b",
               rsp_valid, BREADY, rsp_data, rsp_last, rsp_resp, rsp_write, e.data, e.last, e.resp, e.write);
    end
    @(negedge ACLK);
    BVALID = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL write_done: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  // Locally rejected request: no AXI traffic, one SLVERR response two cycles on.
  task automatic run_reject(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    exp_t e;
    e.data = 32'h0; e.last = 1'b1; e.resp = 2'b10; e.write = wr; e.chk_w = 1'b0;
    sb.push_back(e);
    do_req(wr, addr, len, 1'b0);
    #1;
    checks++;
    if ({rsp_valid, AWVALID, ARVALID} !== 3'b000) begin
      errors++;
      $display("FAIL reject_chk: rsp_valid=%b awvalid=%b arvalid=%b required 0 0 0", rsp_valid, AWVALID, ARVALID);
    end
    @(negedge ACLK);
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_data, rsp_last, rsp_resp, AWVALID, ARVALID} !==
        {1'b1, e.data, e.last, e.resp, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reject_rsp: valid=%b data=%h last=%b resp=%b awvalid=%b arvalid=%b required 1 %h %b %b 0 0",
               rsp_valid, rsp_data, rsp_last, rsp_resp, AWVALID, ARVALID, e.data, e.last, e.resp);
    end
    @(negedge ACLK);
    checks++;
    if ({req_ready, rsp_valid, AWVALID, ARVALID} !== 4'b1000) begin
      errors++;
      $display("FAIL reject_done: req_ready=%b rsp_valid=%b awvalid=%b arvalid=%b required 1 0 0 0",
               req_ready, rsp_valid, AWVALID, ARVALID);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if ({AWVALID, ARVALID, WVALID, BREADY, RREADY, req_ready, wd_ready, rsp_valid, rsp_last,
         rsp_data, rsp_resp, AWADDR, AWLEN, AWLOCK} !== {8'h00, 1'b0, 32'h0, 2'b00, 32'h0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: aw=%b ar=%b w=%b b=%b r=%b req_ready=%b wd_ready=%b rsp_valid=%b addr=%h len=%h required all 0",
               AWVALID, ARVALID, WVALID, BREADY, RREADY, req_ready, wd_ready, rsp_valid, AWADDR, AWLEN);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({req_ready, AWVALID, ARVALID, rsp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle: req_ready=%b aw=%b ar=%b rsp_valid=%b required 1 0 0 0", req_ready, AWVALID, ARVALID, rsp_valid);
    end
  endtask

  task automatic test_read_burst();
    run_read(32'h0000_0100, 8'd3, 1'b0, 2'b00, 0, 32'h0000_00A0);
  endtask

  task automatic test_write_4k_edge();
    run_write(32'h0000_0FF0, 8'd3, 1'b0, 2'b00, 32'h1234_0000);
  endtask

  task automatic test_reject();
    run_reject(1'b1, 32'h0000_0FF4, 8'd3);
    run_reject(1'b0, 32'h0000_0102, 8'd0);
  endtask

  task automatic test_exclusive();
    run_read(32'h0000_0040, 8'd0, 1'b1, 2'b01, 5, 32'h0000_00C0);
    run_write(32'h0000_0080, 8'd0, 1'b1, 2'b01, 32'h0000_00D0);
  endtask

  // Slave raises RLAST on beat 0 of a 2-beat read: flagged, and the read ends.
  task automatic test_early_rlast();
    exp_t e;
    e.data = 32'h0000_00E0; e.last = 1'b0; e.resp = 2'b10; e.write = 1'b0; e.chk_w = 1'b1;
    sb.push_back(e);
    do_req(1'b0, 32'h0000_0200, 8'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (ARVALID === 1'b1) break;
    end
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = 32'h0000_00E0; RLAST = 1'b1; RRESP = 2'b00;
    #1;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_data, rsp_last, rsp_resp} !== {1'b1, e.data, e.last, e.resp}) begin
      errors++;
      $display("FAIL early_rlast_rsp: valid=%b data=%h last=%b resp=%b required 1 %h %b %b",
               rsp_valid, rsp_data, rsp_last, rsp_resp, e.data, e.last, e.resp);
    end
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    checks++;
    if ({req_ready, RREADY} !== 2'b10) begin
      errors++;
      $display("FAIL early_rlast_exit: req_ready=%b rready=%b required 1 0", req_ready, RREADY);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_req(1'b1, 32'h0000_0000, 8'd7, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (AWVALID === 1'b1) break;
    end
    AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0; WREADY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wd_valid = 1'b1; wd_data = 32'h0000_0F00 + k; wd_strb = 4'hF;
      @(negedge ACLK);
    end
    wd_data = 32'h0000_0F02;
    #1;
    checks++;
    if ({WVALID, WLAST, WDATA} !== {1'b1, 1'b0, 32'h0000_0F02}) begin
      errors++;
      $display("FAIL mid_burst_beat2: wvalid=%b wlast=%b wdata=%h required 1 0 00000f02", WVALID, WLAST, WDATA);
    end
    ARESETn = 1'b0;
    #1;
    checks++;
    if ({WVALID, AWVALID, ARVALID, wd_ready, req_ready, rsp_valid} !== 6'b000000) begin
      errors++;
      $display("FAIL mid_burst_reset: wvalid=%b awvalid=%b arvalid=%b wd_ready=%b req_ready=%b rsp_valid=%b required all 0",
               WVALID, AWVALID, ARVALID, wd_ready, req_ready, rsp_valid);
    end
    wd_valid = 1'b0; WREADY = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({req_ready, WVALID, AWVALID} !== 3'b100) begin
      errors++;
      $display("FAIL mid_burst_idle: req_ready=%b wvalid=%b awvalid=%b required 1 0 0", req_ready, WVALID, AWVALID);
    end
    run_read(32'h0000_0300, 8'd1, 1'b0, 2'b00, 0, 32'h0000_00B0);
  endtask

  initial begin
    ARESETn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_len = 8'h0; req_lock = 1'b0;
    wd_valid = 1'b0; wd_data = 32'h0; wd_strb = 4'h0;
    rsp_ready = 1'b1;
    AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
    BID = 4'h0; BRESP = 2'b00; BVALID = 1'b0;
    RID = 4'h0; RDATA = 32'h0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;

    test_reset();
    test_read_burst();
    test_write_4k_edge();
    test_reject();
    test_exclusive();
    test_early_rlast();
    test_reset_mid_burst();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
Blocking single-outstanding bridge from the core's simple request/response memory port to a full AXI4 master port that drives the AXI-to-SRAM slave. It issues one INCR burst of 32-bit beats at a time and never overlaps reads and writes. Bursts that would cross a 4 KB boundary, and misaligned addresses, are rejected locally without any AXI traffic. An exclusive-access flag is forwarded to AxLOCK, and EXOKAY is returned unchanged.

Parameters:
ID_W, 4, AXI ID width
AXI_ID, 4'h0, value driven on AWID/ARID
PROT, 3'b000, value driven on AWPROT/ARPROT

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset; one clock; asynchronous, active-low
req_valid/req_ready  in/out  1/1  request handshake
req_write  in  1  1 = write, 0 = read
req_addr  in  32  byte address of beat 0
req_len  in  8  beats minus 1 (AXI LEN encoding)
req_lock  in  1  exclusive access
wd_valid/wd_ready  in/out  1/1  write-data stream handshake
wd_data  in  32  write-data beat
wd_strb  in  4  write-data byte strobes
rsp_valid/rsp_ready  out/in  1/1  response handshake
rsp_data  out  32  read data; 0 for write responses
rsp_last  out  1  final response of the request
rsp_resp  out  2  OKAY/EXOKAY/SLVERR/DECERR
rsp_write  out  1  response belongs to a write
AW*  out  AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT  (ID_W/32/8/3/2/1/4/3), plus AWVALID out, AWREADY in
W*  out  WDATA 32, WSTRB 4, WLAST 1, WVALID; WREADY in
B  in  BID ID_W, BRESP 2, BVALID; BREADY out
AR*  out  same field set and widths as AW; ARVALID out; ARREADY in
R  in  RID ID_W, RDATA 32, RRESP 2, RLAST 1, RVALID; RREADY out (1 bit)

Behaviour:
- Constant fields: AxSIZE=3'b010, AxBURST=2'b01 (INCR), AxCACHE=4'b0000, AxID=AXI_ID, AxPROT=PROT.
- FSM states: IDLE, CHK, AR, R, AW, W, B, ERR. Reset state is IDLE.
- Reset values: all VALIDs, req_ready, wd_ready, BREADY, RREADY and rsp_* are 0. Address, LEN and LOCK registers are 0.
- IDLE: req_ready=1. On req handshake, latch addr/len/write/lock, then go to CHK.
- CHK (1 cycle):
  - Error if addr[1:0]!=0.
  - Error if addr[11:0] + ((len+1)<<2) > 4096, computed 14 bits wide. Exact end at 4096 is legal.
  - On error go to ERR; otherwise go to AR (read) or AW (write).
- ERR: rsp_valid=1, rsp_resp=2'b10, rsp_last=1, rsp_data=0. Go to IDLE on rsp handshake.
- AR/AW: the VALID is registered and held stable with all fields until READY; there is no combinational dependency of VALID on READY. After the handshake go to R or W.
- W:
  - WVALID=wd_valid, wd_ready=WREADY, WDATA/WSTRB pass through combinationally.
  - An 8-bit beat counter starts at 0; WLAST=(cnt==len).
  - On the last beat handshake go to B. wd_ready=0 in every other state.
- B: BREADY=rsp_ready, rsp_valid=BVALID, rsp_resp=BRESP, rsp_last=1, rsp_write=1. Go to IDLE on the handshake.
- R:
  - RREADY=rsp_ready, rsp_valid=RVALID, rsp_data=RDATA, rsp_last=(cnt==len). Zero added latency.
  - rsp_resp=RRESP, except SLVERR when RLAST != (cnt==len).
  - Leave to IDLE on the handshake where RLAST=1 or cnt==len, whichever comes first; this protects against slave misbehaviour.
- The beat counter increments only on a beat handshake and clears on entry to W or R.
- req_ready=0 outside IDLE, so there is exactly one request in flight.
- RID/BID are ignored; there is no ID checking.
- Asynchronous reset mid-burst returns the FSM to IDLE immediately and deasserts all VALIDs. The slave is reset by the same ARESETn.

Decomposition:
- Package axi_bridge_pkg holds:
  - state enum;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - BURST_INCR, SIZE_4B;
  - function crosses_4k(addr, len).
- Sub-module: none needed. The beat counter and FSM stay in one module.

Test Plan:
- Read addr 0x100, len 3; slave returns 0xA0..0xA3 with RLAST on the 4th beat -> ARLEN=3, ARADDR=0x100; four rsp beats; rsp_last only on 0xA3; resp 0.
- Write addr 0xFF0, len 3, wd_strb 0xF -> legal (ends exactly at 0x1000); WLAST on beat 4; one rsp with rsp_write=1, resp=BRESP.
- Write addr 0xFF4, len 3 -> no AWVALID ever; a single rsp with resp 2'b10 and rsp_last=1 two cycles after the request.
- Read addr 0x102 -> misaligned: SLVERR response, no ARVALID.
- Exclusive read then write with req_lock=1; slave gives EXOKAY -> ARLOCK=AWLOCK=1 and rsp_resp=2'b01 on both. Hold ARREADY=0 for 5 cycles -> ARADDR stable throughout.
- Assert ARESETn=0 during W beat 2 of len 7 -> WVALID/AWVALID fall immediately and the FSM is in IDLE. A subsequent read completes normally.
